// File: rtl/amo_pkg.sv
// -----------------------------------------------------------------------------
// amo_pkg -- types shared by the atomic-memory-operation initiator.
//
// Purpose : Op-code enum, FSM state enum and small decode helpers used by
//           amo_initiator and amo_alu.
// Contents: amo_op_t           4-bit request op codes
//           amo_state_t        initiator FSM states
//           is_amo_op_valid()  op code is one of the defined encodings
//           is_lrsc_op()       op is LR or SC (uses the LRSC address tag)
// -----------------------------------------------------------------------------
package amo_pkg;

    typedef enum logic [3:0] {
        AMO_LR   = 4'd0,
        AMO_SC   = 4'd1,
        AMO_SWAP = 4'd2,
        AMO_ADD  = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amo_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } amo_state_t;

    function automatic logic is_amo_op_valid(input logic [3:0] code);
        return (code <= 4'd10);
    endfunction

    function automatic logic is_lrsc_op(input amo_op_t op);
        return (op == AMO_LR) || (op == AMO_SC);
    endfunction

endpackage : amo_pkg

// File: rtl/amo_tags_pkg.sv
// -----------------------------------------------------------------------------
// amo_tags_pkg -- shared Wishbone address-tag constants.
//
// Purpose : Single source of the address-tag encoding used by atomic-capable
//           initiators and responders on the shared bus.
// Contents: ADDR_TAG_BITS       width of addr_tag_o / addr_tag_i
//           ADDR_TAG_NONE       ordinary (non-atomic) or idle bus
//           ADDR_TAG_MODE_LRSC  load-reserved / store-conditional access
//           ADDR_TAG_MODE_AMO   read-modify-write atomic access
// -----------------------------------------------------------------------------
package amo_tags_pkg;

    localparam int ADDR_TAG_BITS = 2;

    localparam logic [ADDR_TAG_BITS-1:0] ADDR_TAG_NONE      = 2'd0;
    localparam logic [ADDR_TAG_BITS-1:0] ADDR_TAG_MODE_LRSC = 2'd1;
    localparam logic [ADDR_TAG_BITS-1:0] ADDR_TAG_MODE_AMO  = 2'd2;

endpackage : amo_tags_pkg

// File: rtl/amo_alu.sv
// -----------------------------------------------------------------------------
// amo_alu -- combinational read-modify-write datapath for AMO operations.
//
// Purpose : Computes the value written back by an AMO from the old memory
//           word and the request operand. All results are 32 bits wide.
// Ports   : op       in   amo_op_t  captured request op
//           old_val  in   32        value returned by the AMO read phase
//           operand  in   32        request operand
//           result   out  32        value for the AMO write phase
// -----------------------------------------------------------------------------
module amo_alu
    import amo_pkg::*;
(
    input  amo_op_t     op,
    input  logic [31:0] old_val,
    input  logic [31:0] operand,
    output logic [31:0] result
);

    logic signed [31:0] old_s;
    logic signed [31:0] operand_s;

    assign old_s     = old_val;
    assign operand_s = operand;

    always_comb begin
        result = operand;
        case (op)
            AMO_SWAP: result = operand;
            AMO_ADD:  result = old_val + operand;   // wraps mod 2^32
            AMO_XOR:  result = old_val ^ operand;
            AMO_AND:  result = old_val & operand;
            AMO_OR:   result = old_val | operand;
            AMO_MIN:  result = (old_s < operand_s) ? old_val : operand;
            AMO_MAX:  result = (old_s > operand_s) ? old_val : operand;
            AMO_MINU: result = (old_val < operand) ? old_val : operand;
            AMO_MAXU: result = (old_val > operand) ? old_val : operand;
            default:  result = operand;             // LR/SC never write via ALU
        endcase
    end

endmodule : amo_alu

// File: rtl/amo_initiator.sv
// -----------------------------------------------------------------------------
// amo_initiator -- Wishbone initiator executing LR / SC / AMO requests.
//
// Purpose : Accepts one atomic request at a time from the core and runs it
//           on the bus as READ, optional CALC, WRITE phases, then returns a
//           single-cycle response.
//             LR  : READ (tag LRSC)                     -> rsp = read data
//             SC  : WRITE (tag LRSC, data = operand)    -> rsp = data_tag_i
//             AMO : READ (tag AMO), CALC, WRITE (tag AMO, data = op(old,opnd))
//                                                       -> rsp = old value
//           Misaligned addresses or unknown op codes respond with an error
//           and never start a bus cycle. err_i aborts any phase.
//
// Config  : `define AMO_INITIATOR_TIMEOUT_EN to bound every bus phase to
//           TIMEOUT_CYCLES cycles; an expired phase responds with an error.
//           Without it phases wait indefinitely and no counter exists.
//
// Ports   : clk_i, rst_i (async, active-low)
//           core   : req_valid_i, req_ready_o, req_op_i[3:0], req_addr_i[31:0],
//                    req_data_i[31:0], rsp_valid_o, rsp_data_o[31:0], rsp_err_o
//           bus out: stb_o, cyc_o, we_o, addr_o[31:0], addr_tag_o, data_o[31:0],
//                    sel_o[3:0]
//           bus in : ack_i, err_i, data_tag_i, data_i[31:0]
// -----------------------------------------------------------------------------
module amo_initiator
    import amo_pkg::*;
    import amo_tags_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [3:0]               req_op_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_data_i,

    output logic                     rsp_valid_o,
    output logic [31:0]              rsp_data_o,
    output logic                     rsp_err_o,

    output logic                     stb_o,
    output logic                     cyc_o,
    output logic                     we_o,
    output logic [31:0]              addr_o,
    output logic [ADDR_TAG_BITS-1:0] addr_tag_o,
    output logic [31:0]              data_o,
    output logic [3:0]               sel_o,

    input  logic                     ack_i,
    input  logic                     err_i,
    input  logic                     data_tag_i,
    input  logic [31:0]              data_i
);

    amo_state_t  state;
    amo_state_t  state_nx;

    amo_op_t     op_q;
    logic [31:0] operand_q;
    logic [31:0] old_q;
    logic [31:0] alu_result;

    logic        bus_active;
    logic        timeout;

    logic        load_req;
    logic        load_old;
    logic        load_wdata;
    logic        rsp_load;
    logic        rsp_err_nx;
    logic [31:0] rsp_data_nx;

    assign bus_active = (state == ST_READ) || (state == ST_WRITE);

    // ------------------------------------------------------------------
    // Optional phase watchdog
    // ------------------------------------------------------------------
`ifdef AMO_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic          waiting;

    assign waiting = bus_active && !ack_i && !err_i;

    // Counter restarts at every phase entry because it is cleared whenever
    // the bus is idle or the responder answered. Firing on TIMEOUT_CYCLES-1
    // keeps stb_o high for exactly TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = waiting && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath load controls
    // ------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        load_req    = 1'b0;
        load_old    = 1'b0;
        load_wdata  = 1'b0;
        rsp_load    = 1'b0;
        rsp_err_nx  = 1'b0;
        rsp_data_nx = '0;

        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    load_req = 1'b1;
                    if ((req_addr_i[1:0] != 2'b00) || !is_amo_op_valid(req_op_i)) begin
                        state_nx   = ST_RESP;
                        rsp_load   = 1'b1;
                        rsp_err_nx = 1'b1;
                    end else if (req_op_i == AMO_SC) begin
                        state_nx = ST_WRITE;
                    end else begin
                        state_nx = ST_READ;
                    end
                end
            end

            ST_READ: begin
                // err_i takes priority over a simultaneous ack_i
                if (err_i || timeout) begin
                    state_nx   = ST_RESP;
                    rsp_load   = 1'b1;
                    rsp_err_nx = 1'b1;
                end else if (ack_i) begin
                    if (op_q == AMO_LR) begin
                        state_nx    = ST_RESP;
                        rsp_load    = 1'b1;
                        rsp_data_nx = data_i;
                    end else begin
                        load_old = 1'b1;
                        state_nx = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                load_wdata = 1'b1;
                state_nx   = ST_WRITE;
            end

            ST_WRITE: begin
                if (err_i || timeout) begin
                    state_nx   = ST_RESP;
                    rsp_load   = 1'b1;
                    rsp_err_nx = 1'b1;
                end else if (ack_i) begin
                    state_nx    = ST_RESP;
                    rsp_load    = 1'b1;
                    rsp_data_nx = (op_q == AMO_SC) ? {31'd0, data_tag_i} : old_q;
                end
            end

            ST_RESP: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, old-value latch, write data and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q       <= AMO_LR;
            operand_q  <= '0;
            old_q      <= '0;
            addr_o     <= '0;
            data_o     <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
        end else begin
            if (load_req) begin
                op_q      <= amo_op_t'(req_op_i);
                operand_q <= req_data_i;
                addr_o    <= req_addr_i;
                // SC writes the operand directly; AMOs overwrite this in CALC
                data_o    <= req_data_i;
            end
            if (load_old) begin
                old_q <= data_i;
            end
            if (load_wdata) begin
                data_o <= alu_result;
            end
            if (rsp_load) begin
                rsp_data_o <= rsp_data_nx;
                rsp_err_o  <= rsp_err_nx;
            end
        end
    end

    amo_alu u_alu (
        .op      (op_q),
        .old_val (old_q),
        .operand (operand_q),
        .result  (alu_result)
    );

    // ------------------------------------------------------------------
    // Outputs decoded from state so reset forces the bus idle at once
    // ------------------------------------------------------------------
    assign req_ready_o = (state == ST_IDLE);
    assign rsp_valid_o = (state == ST_RESP);
    assign stb_o       = bus_active;
    assign cyc_o       = bus_active;
    assign we_o        = (state == ST_WRITE);
    assign sel_o       = 4'b1111;
    assign addr_tag_o  = !bus_active      ? ADDR_TAG_NONE      :
                         is_lrsc_op(op_q) ? ADDR_TAG_MODE_LRSC :
                                            ADDR_TAG_MODE_AMO;

endmodule : amo_initiator
